// File: rtl/sub_div_pkg.sv
// Shared types and constants for the restoring-division controller.
// Every file that touches the divider state or result encodings imports this package.
package sub_div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = {DIV_WIDTH{1'b1}};
    localparam logic [DIV_WIDTH-1:0] SIGNED_MIN    = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/sub_div_ctrl_if.sv
// Request/response handshake bundle between the execute stage and the divide unit.
// The master side issues requests and consumes results; the slave side is the divider.
interface sub_div_ctrl_if #(
    parameter int WIDTH = sub_div_pkg::DIV_WIDTH
);

    logic             req_valid;
    logic             req_ready;
    logic             req_signed;
    logic [WIDTH-1:0] req_dividend;
    logic [WIDTH-1:0] req_divisor;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_quotient;
    logic [WIDTH-1:0] rsp_remainder;
    logic             rsp_div_zero;
    logic             rsp_overflow;
    logic             busy;

    modport master (
        output req_valid, req_signed, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder,
        input  rsp_div_zero, rsp_overflow, busy
    );

    modport slave (
        input  req_valid, req_signed, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder,
        output rsp_div_zero, rsp_overflow, busy
    );

endinterface

// File: rtl/sub_div_ctrl_subtractor.sv
// The existing shared subtractor unit: Diff = A - B modulo 2^WIDTH.
// Cout is the inverted borrow, so it is high exactly when A >= B as unsigned values.
module subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Cout
);

    logic [WIDTH:0] full_s;

    // Widen by one bit so the top bit of the result is the borrow
    always_comb begin
        full_s = {1'b0, A} - {1'b0, B};
        Diff   = full_s[WIDTH-1:0];
        Cout   = ~full_s[WIDTH];
    end

endmodule

// File: rtl/sub_div_ctrl.sv
// Restoring signed/unsigned divider; every trial subtraction goes through one shared
// subtractor, producing one quotient bit per ITER cycle. All outputs are registered.
module sub_div_ctrl
    import sub_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    sub_div_ctrl_if.slave   bus
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             div0_q, div0_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] dsr_mag_q, dsr_mag_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] sub_diff_s;
    logic             sub_cout_s;
    logic             q_bit_s;

    subtractor #(.WIDTH(WIDTH)) u_sub (
        .A    (shifted_s[WIDTH-1:0]),
        .B    (dsr_mag_q),
        .Diff (sub_diff_s),
        .Cout (sub_cout_s)
    );

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        logic [WIDTH-1:0] r;
        if (en) begin
            r = ~v + ONE_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Next-state, datapath and registered-output computation for the divider FSM
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        div0_d      = div0_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dsr_mag_d   = dsr_mag_q;
        shreg_d     = shreg_q;
        prem_d      = prem_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        // A quotient bit is forced when the shifted-out MSB makes the trial value exceed WIDTH bits
        shifted_s   = {prem_q, shreg_q[WIDTH-1]};
        q_bit_s     = shifted_s[WIDTH] | sub_cout_s;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    a_d     = bus.req_dividend;
                    b_d     = bus.req_divisor;
                    sgn_d   = bus.req_signed;
                    state_d = ST_PREP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                // Divide-by-zero still passes through FIX so both result paths share one writer
                if (b_q == ZERO_W) begin
                    div0_d  = 1'b1;
                    state_d = ST_FIX;
                end else begin
                    div0_d    = 1'b0;
                    q_neg_d   = (sgn_q & a_q[WIDTH-1]) ^ (sgn_q & b_q[WIDTH-1]);
                    r_neg_d   = sgn_q & a_q[WIDTH-1];
                    shreg_d   = neg_if(a_q, sgn_q & a_q[WIDTH-1]);
                    dsr_mag_d = neg_if(b_q, sgn_q & b_q[WIDTH-1]);
                    prem_d    = ZERO_W;
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = ST_ITER;
                end
            end
            ST_ITER: begin
                if (q_bit_s) begin
                    prem_d = sub_diff_s;
                end else begin
                    prem_d = shifted_s[WIDTH-1:0];
                end
                shreg_d = {shreg_q[WIDTH-2:0], q_bit_s};
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_FIX: begin
                if (div0_q) begin
                    quo_d = DIV0_QUOTIENT;
                    rem_d = a_q;
                    dz_d  = 1'b1;
                    ovf_d = 1'b0;
                end else begin
                    quo_d = neg_if(shreg_q, q_neg_q);
                    rem_d = neg_if(prem_q, r_neg_q);
                    dz_d  = 1'b0;
                    ovf_d = sgn_q && (a_q == SIGNED_MIN) && (b_q == ONES_W);
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= ZERO_W;
            b_q         <= ZERO_W;
            sgn_q       <= 1'b0;
            div0_q      <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dsr_mag_q   <= ZERO_W;
            shreg_q     <= ZERO_W;
            prem_q      <= ZERO_W;
            cnt_q       <= {CNT_W{1'b0}};
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            quo_q       <= ZERO_W;
            rem_q       <= ZERO_W;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            div0_q      <= div0_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dsr_mag_q   <= dsr_mag_d;
            shreg_q     <= shreg_d;
            prem_q      <= prem_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.busy          = busy_q;
    assign bus.rsp_quotient  = quo_q;
    assign bus.rsp_remainder = rem_q;
    assign bus.rsp_div_zero  = dz_q;
    assign bus.rsp_overflow  = ovf_q;

endmodule

// File: tb/tb_sub_div_ctrl.sv
// Directed plus randomized bench for sub_div_ctrl, checked against an arithmetic
// reference model (integer / and %) rather than a bit-serial one.
module tb_sub_div_ctrl;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    sub_div_ctrl_if bus_if ();

    sub_div_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; signed / and % truncate toward zero
    task automatic model(input logic s, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov);
        int ai;
        int bi;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 8'd0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            ai = int'($signed(a));
            bi = int'($signed(b));
            if (ai == -128 && bi == -1) begin
                q  = 8'h80;
                r  = 8'h00;
                ov = 1'b1;
            end else begin
                q = 8'(ai / bi);
                r = 8'(ai % bi);
            end
        end else begin
            q = 8'(int'(a) / int'(b));
            r = 8'(int'(a) % int'(b));
        end
    endtask

    task automatic do_op(input string tag, input logic s, input logic [7:0] a,
                         input logic [7:0] b, input int hold);
        logic [7:0] eq, er;
        logic       edz, eov;
        int         lat;
        int         exp_lat;
        model(s, a, b, eq, er, edz, eov);
        exp_lat = edz ? 2 : 10;
        @(negedge clk);
        chk({tag, ".req_ready_idle"}, 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid    = 1'b1;
        bus_if.req_signed   = s;
        bus_if.req_dividend = a;
        bus_if.req_divisor  = b;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        chk({tag, ".busy"}, {30'd0, bus_if.busy, bus_if.req_ready}, 32'd2);
        while (!bus_if.rsp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".quotient"}, 32'(bus_if.rsp_quotient), 32'(eq));
        chk({tag, ".remainder"}, 32'(bus_if.rsp_remainder), 32'(er));
        chk({tag, ".flags"}, {30'd0, bus_if.rsp_div_zero, bus_if.rsp_overflow}, {30'd0, edz, eov});
        // Hold the result with rsp_ready low while a stray request is offered
        for (int i = 0; i < hold; i++) begin
            bus_if.req_valid    = (i < hold - 1) ? 1'b1 : 1'b0;
            bus_if.req_dividend = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold"}, {bus_if.rsp_valid, bus_if.req_ready, bus_if.rsp_div_zero,
                                 bus_if.rsp_overflow, 12'd0, bus_if.rsp_quotient, bus_if.rsp_remainder},
                                {1'b1, 1'b0, edz, eov, 12'd0, eq, er});
        end
        bus_if.req_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
        chk({tag, ".release"}, {29'd0, bus_if.rsp_valid, bus_if.req_ready, bus_if.busy}, 32'd2);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rs;
        int         saw_valid;
        tests               = 0;
        failed              = 0;
        rst_n               = 1'b0;
        bus_if.req_valid    = 1'b0;
        bus_if.req_signed   = 1'b0;
        bus_if.req_dividend = 8'd0;
        bus_if.req_divisor  = 8'd0;
        bus_if.rsp_ready    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.ctrl", {29'd0, bus_if.req_ready, bus_if.rsp_valid, bus_if.busy}, 32'd4);
        chk("reset.data", {14'd0, bus_if.rsp_div_zero, bus_if.rsp_overflow,
                           bus_if.rsp_quotient, bus_if.rsp_remainder}, 32'd0);
        rst_n = 1'b1;

        do_op("u69_42",   1'b0, 8'd69,  8'd42,  0);
        do_op("s-42_5",   1'b1, 8'hD6,  8'h05,  1);
        do_op("u255_1",   1'b0, 8'd255, 8'd1,   0);
        do_op("u0_127",   1'b0, 8'd0,   8'd127, 0);
        do_op("div0",     1'b0, 8'd42,  8'd0,   5);
        do_op("s-128_-1", 1'b1, 8'h80,  8'hFF,  0);
        do_op("u128_255", 1'b0, 8'h80,  8'hFF,  0);
        do_op("s-128_1",  1'b1, 8'h80,  8'h01,  0);
        do_op("s-div0",   1'b1, 8'hC3,  8'h00,  2);

        // Reset in the middle of the iteration phase must drop the operation
        @(negedge clk);
        bus_if.req_valid    = 1'b1;
        bus_if.req_signed   = 1'b0;
        bus_if.req_dividend = 8'd200;
        bus_if.req_divisor  = 8'd3;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset.ctrl", {29'd0, bus_if.req_ready, bus_if.rsp_valid, bus_if.busy}, 32'd4);
        rst_n            = 1'b1;
        bus_if.rsp_ready = 1'b1;
        saw_valid        = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_if.rsp_valid) saw_valid++;
        end
        bus_if.rsp_ready = 1'b0;
        chk("midreset.no_rsp", 32'(saw_valid), 32'd0);
        do_op("u100_7", 1'b0, 8'd100, 8'd7, 0);

        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom);
            ra = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 8'h00;
                1:       rb = 8'hFF;
                default: rb = 8'($urandom);
            endcase
            do_op("rand", rs, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
